apb_timer_multi: RTL

//  Parametrised APB timer bank: NumTimers independent up-counters, each with prescaler, compare,
//  one-shot/periodic mode and a maskable level IRQ. Sits behind an AXI-to-APB bridge (32-bit APB)
//  in the peripheral subsystem; irq_o feeds PLIC sources. Generalises the fixed 2-timer APB timer.

---
 rtl/apb_timer_pkg.sv | 32 +++
 rtl/apb_timer_chan.sv | 114 +++++++++++
 rtl/apb_timer_multi.sv | 88 ++++++++
 3 files changed

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer bank: register offsets, control
// register layout and address decode helpers.
package apb_timer_pkg;

    // Word offsets of the per-channel registers (paddr[3:2]).
    localparam logic [1:0] REG_CNT    = 2'd0;
    localparam logic [1:0] REG_CMP    = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Widest prescaler field the control register can carry.
    localparam int PRESC_MAX_W = 16;

    // Control register contents; presc bits above the channel's PrescWidth stay 0.
    typedef struct packed {
        logic [PRESC_MAX_W-1:0] presc;
        logic                   ien;
        logic                   oneshot;
        logic                   en;
    } ctrl_t;

    // Channel number from the low address byte (16 bytes per channel).
    function automatic logic [3:0] chan_idx(input logic [7:0] addr);
        return 4'(addr >> 4);
    endfunction

    // Register word offset inside a channel.
    function automatic logic [1:0] reg_off(input logic [7:0] addr);
        return 2'(addr >> 2);
    endfunction

endpackage

// File: rtl/apb_timer_chan.sv
// One timer channel: prescaler, up-counter with compare, one-shot/periodic
// control, W1C pending flag and registered interrupt output.
module apb_timer_chan
    import apb_timer_pkg::*;
#(
    parameter int CntWidth   = 32,
    parameter int PrescWidth = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_cnt,
    input  logic        wr_cmp,
    input  logic        wr_ctrl,
    input  logic        wr_status,
    input  logic [31:0] wdata,
    output logic [31:0] cnt_rd,
    output logic [31:0] cmp_rd,
    output logic [31:0] ctrl_rd,
    output logic [31:0] status_rd,
    output logic        irq
);

    logic [CntWidth-1:0]   cnt_q;
    logic [CntWidth-1:0]   cmp_q;
    ctrl_t                 ctrl_q;
    ctrl_t                 ctrl_wr;
    logic [PrescWidth-1:0] pc_q;
    logic                  pending_q;
    logic                  irq_q;
    logic                  tick;
    logic                  match;
    logic                  unused_wdata;

    // Bits of wdata beyond the implemented register fields are ignored.
    assign unused_wdata = ^wdata;

    // A tick fires on the cycle the prescale counter reaches PRESC.
    assign tick  = ctrl_q.en && (16'(pc_q) == ctrl_q.presc);
    // Compare uses the register values from before this edge.
    assign match = tick && (cnt_q == cmp_q);

    // Control word as it will be stored on a CTRL write (unused presc bits forced 0).
    always_comb begin
        ctrl_wr         = '0;
        ctrl_wr.presc   = 16'(wdata[8 +: PrescWidth]);
        ctrl_wr.ien     = wdata[2];
        ctrl_wr.oneshot = wdata[1];
        ctrl_wr.en      = wdata[0];
    end

    // Prescaler, counter, compare and control; later software writes override hardware updates.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            cmp_q  <= '0;
            ctrl_q <= '0;
            pc_q   <= '0;
        end else begin
            if (ctrl_q.en) begin
                pc_q <= tick ? '0 : pc_q + PrescWidth'(1);
            end
            if (tick) begin
                cnt_q <= match ? '0 : cnt_q + CntWidth'(1);
            end
            if (match && ctrl_q.oneshot) begin
                ctrl_q.en <= 1'b0;
            end
            if (wr_cnt) begin
                cnt_q <= wdata[CntWidth-1:0];
                pc_q  <= '0;
            end
            if (wr_cmp) begin
                cmp_q <= wdata[CntWidth-1:0];
            end
            if (wr_ctrl) begin
                ctrl_q <= ctrl_wr;
                // Enabling a stopped timer restarts its prescale period.
                if (!ctrl_q.en && wdata[0]) begin
                    pc_q <= '0;
                end
            end
        end
    end

    // Pending flag (hardware set beats W1C) and the registered interrupt level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (match) begin
                pending_q <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                pending_q <= 1'b0;
            end
            irq_q <= pending_q & ctrl_q.ien;
        end
    end

    // Register read values, zero-extended to the 32-bit bus.
    always_comb begin
        ctrl_rd         = '0;
        ctrl_rd[0]      = ctrl_q.en;
        ctrl_rd[1]      = ctrl_q.oneshot;
        ctrl_rd[2]      = ctrl_q.ien;
        ctrl_rd[8 +: 16] = ctrl_q.presc;
    end

    assign cnt_rd    = 32'(cnt_q);
    assign cmp_rd    = 32'(cmp_q);
    assign status_rd = {31'd0, pending_q};
    assign irq       = irq_q;

endmodule

// File: rtl/apb_timer_multi.sv
// APB timer bank: NumTimers independent channels behind a zero-wait-state
// APB slave. Channel i lives at byte offset 0x10*i; unmapped channels error.
module apb_timer_multi
    import apb_timer_pkg::*;
#(
    parameter int NumTimers    = 4,
    parameter int CntWidth     = 32,
    parameter int PrescWidth   = 8,
    parameter int ApbAddrWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ApbAddrWidth-1:0] paddr_i,
    input  logic [31:0]             pwdata_i,
    output logic [31:0]             prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [NumTimers-1:0]    irq_o
);

    // APB handshake: psel_i & penable_i is the access phase; with pready_o tied
    // high every access completes on that edge (writes commit, reads sample).
    logic        access;
    logic        wr_en;
    logic        in_range;
    logic [3:0]  chan;
    logic [1:0]  off;
    logic        unused_paddr;
    logic [31:0] cnt_rd    [NumTimers];
    logic [31:0] cmp_rd    [NumTimers];
    logic [31:0] ctrl_rd   [NumTimers];
    logic [31:0] status_rd [NumTimers];

    assign access       = psel_i & penable_i;
    assign chan         = chan_idx(paddr_i[7:0]);
    assign off          = reg_off(paddr_i[7:0]);
    assign in_range     = ({28'd0, chan} < 32'(NumTimers));
    assign wr_en        = access & pwrite_i & in_range;
    // Address bits outside [7:2] do not take part in decode.
    assign unused_paddr = ^{paddr_i[ApbAddrWidth-1:8], paddr_i[1:0]};

    for (genvar g = 0; g < NumTimers; g++) begin : g_chan
        logic sel;
        assign sel = wr_en && (chan == 4'(g));

        apb_timer_chan #(
            .CntWidth   (CntWidth),
            .PrescWidth (PrescWidth)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .wr_cnt    (sel && (off == REG_CNT)),
            .wr_cmp    (sel && (off == REG_CMP)),
            .wr_ctrl   (sel && (off == REG_CTRL)),
            .wr_status (sel && (off == REG_STATUS)),
            .wdata     (pwdata_i),
            .cnt_rd    (cnt_rd[g]),
            .cmp_rd    (cmp_rd[g]),
            .ctrl_rd   (ctrl_rd[g]),
            .status_rd (status_rd[g]),
            .irq       (irq_o[g])
        );
    end

    // Read mux: data only during a valid access phase, zero otherwise.
    always_comb begin
        prdata_o = '0;
        if (access && in_range) begin
            for (int i = 0; i < NumTimers; i++) begin
                if (chan == 4'(i)) begin
                    case (off)
                        REG_CNT:  prdata_o = cnt_rd[i];
                        REG_CMP:  prdata_o = cmp_rd[i];
                        REG_CTRL: prdata_o = ctrl_rd[i];
                        default:  prdata_o = status_rd[i];
                    endcase
                end
            end
        end
    end

    assign pslverr_o = access & ~in_range;
    assign pready_o  = 1'b1;

endmodule
